// File: rtl/sha256_block_controller_if.sv
// Message stream, scheduler, compression-core and digest signals of the SHA-256 block controller.
// master = host/datapath environment, slave = the controller itself.
interface sha256_block_controller_if;
    logic         init;
    logic         msg_valid;
    logic         msg_ready;
    logic [31:0]  msg_word;
    logic         msg_last;
    logic         sched_load;
    logic [3:0]   sched_idx;
    logic [31:0]  sched_word;
    logic         sched_step;
    logic         core_start;
    logic [5:0]   core_round;
    logic [255:0] core_H_in;
    logic [255:0] core_H_out;
    logic         core_done;
    logic         busy;
    logic [255:0] digest;
    logic         digest_valid;
    logic         error;

    modport master (
        output init, msg_valid, msg_word, msg_last, core_H_out, core_done,
        input  msg_ready, sched_load, sched_idx, sched_word, sched_step,
               core_start, core_round, core_H_in, busy, digest, digest_valid, error
    );

    modport slave (
        input  init, msg_valid, msg_word, msg_last, core_H_out, core_done,
        output msg_ready, sched_load, sched_idx, sched_word, sched_step,
               core_start, core_round, core_H_in, busy, digest, digest_valid, error
    );
endinterface

// File: rtl/sha256_block_controller.sv
// Sequences 16-word block loads into the message scheduler, runs 64 compression rounds
// and chains each block's hash into the next; publishes the final digest with a pulse.
//
// state | meaning
// IDLE  | waiting for init; digest held
// LOAD  | accepting words W0..W15 into scheduler slots
// START | one-cycle core start; core samples the chaining value
// RUN   | rounds 0..63, scheduler stepped every cycle
// WAIT  | waiting for core_done, bounded by TIMEOUT cycles
module sha256_block_controller #(
    parameter int unsigned  TIMEOUT = 8,
    parameter logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    sha256_block_controller_if.slave  bus
);

    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_WAIT
    } state_t;

    state_t         state_q;
    logic [3:0]     word_q;
    logic [5:0]     round_q;
    logic [WW-1:0]  wait_q;
    logic           last_q;
    logic [255:0]   chain_q;
    logic [255:0]   digest_q;
    logic           digest_valid_q;
    logic           error_q;
    logic           handshake;

    assign handshake = (state_q == S_LOAD) && bus.msg_valid;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            word_q         <= '0;
            round_q        <= '0;
            wait_q         <= '0;
            last_q         <= 1'b0;
            chain_q        <= IV;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            digest_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.init) begin
                        chain_q <= IV;
                        word_q  <= '0;
                        error_q <= 1'b0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (handshake) begin
                        // msg_last only matters on the word that closes the block
                        if (word_q == 4'd15) begin
                            last_q  <= bus.msg_last;
                            word_q  <= '0;
                            state_q <= S_START;
                        end else begin
                            word_q <= word_q + 4'd1;
                        end
                    end
                end
                S_START: begin
                    round_q <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (round_q == 6'd63) begin
                        wait_q  <= WW'(TIMEOUT - 1);
                        state_q <= S_WAIT;
                    end else begin
                        round_q <= round_q + 6'd1;
                    end
                end
                S_WAIT: begin
                    if (bus.core_done) begin
                        chain_q <= bus.core_H_out;
                        if (last_q) begin
                            digest_q       <= bus.core_H_out;
                            digest_valid_q <= 1'b1;
                            state_q        <= S_IDLE;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end else if (wait_q == '0) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wait_q <= wait_q - WW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.msg_ready    = (state_q == S_LOAD);
    assign bus.sched_load   = handshake;
    assign bus.sched_idx    = word_q;
    assign bus.sched_word   = (state_q == S_LOAD) ? bus.msg_word : 32'd0;
    assign bus.sched_step   = (state_q == S_RUN);
    assign bus.core_start   = (state_q == S_START);
    assign bus.core_round   = round_q;
    assign bus.core_H_in    = chain_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.digest       = digest_q;
    assign bus.digest_valid = digest_valid_q;
    assign bus.error        = error_q;

endmodule

// File: tb/tb_sha256_block_controller.sv
// Testbench for sha256_block_controller: plays host, scheduler and compression core,
// with a scoreboard of expected loads, chaining values and digests from a SHA-256 model.
module tb_sha256_block_controller;

    localparam int           TIMEOUT = 8;
    localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_D   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO_D   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk;
    logic reset;

    sha256_block_controller_if bus_if ();

    sha256_block_controller #(.TIMEOUT(TIMEOUT), .IV(IV)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            ncmp = 0;
    int            nfail = 0;
    int            cyc = 0;
    int            load0_cyc = 0;
    int            dv_cyc = 0;
    logic [31:0]   cur_msg [$];
    logic [35:0]   load_q [$];
    logic [255:0]  hin_q [$];
    logic [255:0]  dig_q [$];
    logic [31:0]   sched_mem [16];
    logic [255:0]  last_digest = '0;
    bit            abort_ok = 1'b0;
    bit            withhold = 1'b0;
    int            dly_fix = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [31:0] m [16]);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = m[t];
        for (int t = 16; t < 64; t++) begin
            s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_msg_ready"},    256'(bus_if.msg_ready),    256'(0));
        check({tag, "_sched_load"},   256'(bus_if.sched_load),   256'(0));
        check({tag, "_sched_idx"},    256'(bus_if.sched_idx),    256'(0));
        check({tag, "_sched_word"},   256'(bus_if.sched_word),   256'(0));
        check({tag, "_sched_step"},   256'(bus_if.sched_step),   256'(0));
        check({tag, "_core_start"},   256'(bus_if.core_start),   256'(0));
        check({tag, "_core_round"},   256'(bus_if.core_round),   256'(0));
        check({tag, "_core_H_in"},    bus_if.core_H_in,          IV);
        check({tag, "_busy"},         256'(bus_if.busy),         256'(0));
        check({tag, "_digest"},       bus_if.digest,             256'(0));
        check({tag, "_digest_valid"}, 256'(bus_if.digest_valid), 256'(0));
        check({tag, "_error"},        256'(bus_if.error),        256'(0));
    endtask

    task automatic set_abc();
        cur_msg.delete();
        cur_msg.push_back(32'h61626380);
        repeat (14) cur_msg.push_back(32'h0);
        cur_msg.push_back(32'h00000018);
    endtask

    task automatic set_two();
        logic [31:0] b1 [16] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        cur_msg.delete();
        for (int i = 0; i < 16; i++) cur_msg.push_back(b1[i]);
        repeat (15) cur_msg.push_back(32'h0);
        cur_msg.push_back(32'h000001c0);
    endtask

    task automatic set_random(input int nb);
        cur_msg.delete();
        repeat (nb * 16) cur_msg.push_back($urandom);
    endtask

    // Pushes expectations for cur_msg, pulses init and streams the words in.
    task automatic send_msg(input bit gap, input bit use_known, input logic [255:0] known,
                            input bit no_digest, input bit noise);
        int           n;
        int           idx;
        int           guard;
        bit           hs;
        logic [255:0] h;
        logic [31:0]  blk [16];
        n = cur_msg.size();
        h = IV;
        for (int b = 0; b < n / 16; b++) begin
            for (int i = 0; i < 16; i++) begin
                blk[i] = cur_msg[b * 16 + i];
                load_q.push_back({4'(i), blk[i]});
            end
            hin_q.push_back(h);
            h = sha_compress(h, blk);
        end
        if (!no_digest) dig_q.push_back(use_known ? known : h);

        @(posedge clk); #1;
        bus_if.init = 1'b1;
        @(posedge clk); #1;
        bus_if.init = 1'b0;
        check("init_clears_error", 256'(bus_if.error), 256'(0));
        check("init_to_load",      256'(bus_if.msg_ready), 256'(1));

        idx = 0;
        guard = 0;
        while (idx < n && guard < 4000) begin
            hs = 1'b0;
            if (gap && $urandom_range(0, 1) == 0) begin
                bus_if.msg_valid = 1'b0;
                bus_if.msg_word  = $urandom;
                bus_if.msg_last  = 1'($urandom_range(0, 1));
            end else begin
                bus_if.msg_valid = 1'b1;
                bus_if.msg_word  = cur_msg[idx];
                if (idx % 16 == 15) bus_if.msg_last = (idx == n - 1);
                else                bus_if.msg_last = noise ? 1'b1 : 1'($urandom_range(0, 1));
                hs = bus_if.msg_ready;
            end
            @(posedge clk); #1;
            if (hs) idx++;
            guard++;
        end
        bus_if.msg_valid = 1'b0;
        bus_if.msg_last  = 1'b0;
        check("words_accepted", 256'(idx), 256'(n));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.busy && n < 2000);
        check(name, 256'(bus_if.busy), 256'(0));
    endtask

    task automatic wait_round(input int r);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus_if.sched_step && bus_if.core_round == 6'(r)) && n < 500);
        check("reach_round", 256'(bus_if.sched_step && bus_if.core_round == 6'(r)), 256'(1));
    endtask

    // Scoreboard monitor: loads, chaining values at core_start, digests.
    initial begin
        logic [35:0]  e;
        logic [255:0] x;
        bit           prev_dv;
        prev_dv = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.sched_load) begin
                if (load_q.size() == 0) begin
                    ncmp++; nfail++;
                    $display("FAIL sched_load_unexpected: idx %0d word %h", bus_if.sched_idx, bus_if.sched_word);
                end else begin
                    e = load_q.pop_front();
                    check("sched_idx",  256'(bus_if.sched_idx),  256'(e[35:32]));
                    check("sched_word", 256'(bus_if.sched_word), 256'(e[31:0]));
                end
                sched_mem[bus_if.sched_idx] = bus_if.sched_word;
                if (bus_if.sched_idx == 4'd0) load0_cyc = cyc;
            end
            if (bus_if.core_start) begin
                if (hin_q.size() == 0) begin
                    ncmp++; nfail++;
                    $display("FAIL core_start_unexpected: H_in %h", bus_if.core_H_in);
                end else begin
                    x = hin_q.pop_front();
                    check("core_H_in", bus_if.core_H_in, x);
                end
            end
            if (bus_if.digest_valid) begin
                dv_cyc = cyc;
                if (prev_dv) begin
                    ncmp++; nfail++;
                    $display("FAIL digest_valid_pulse: high %0d cycles in a row, expected 1", 2);
                end else if (dig_q.size() == 0) begin
                    ncmp++; nfail++;
                    $display("FAIL digest_valid_unexpected: digest %h", bus_if.digest);
                end else begin
                    x = dig_q.pop_front();
                    check("digest", bus_if.digest, x);
                    last_digest = x;
                end
            end
            prev_dv = bus_if.digest_valid;
        end
    end

    // Compression core + scheduler stand-in: checks the round sequence and answers core_done.
    initial begin
        logic [255:0] hin;
        logic [31:0]  blk [16];
        bit           ab;
        int           dly;
        bus_if.core_done  = 1'b0;
        bus_if.core_H_out = '0;
        forever begin
            @(negedge clk);
            if (bus_if.core_start) begin
                hin = bus_if.core_H_in;
                blk = sched_mem;
                ab  = 1'b0;
                for (int t = 0; t < 64; t++) begin
                    @(negedge clk);
                    if (!bus_if.sched_step && abort_ok) begin
                        ab = 1'b1;
                        break;
                    end
                    check("sched_step", 256'(bus_if.sched_step), 256'(1));
                    check("core_round", 256'(bus_if.core_round), 256'(t));
                end
                if (!ab) begin
                    check("core_H_in_stable", bus_if.core_H_in, hin);
                    if (!withhold) begin
                        dly = (dly_fix != 0) ? dly_fix : int'($urandom_range(1, TIMEOUT));
                        repeat (dly) @(posedge clk);
                        #1;
                        bus_if.core_done  = 1'b1;
                        bus_if.core_H_out = sha_compress(hin, blk);
                        @(posedge clk); #1;
                        bus_if.core_done  = 1'b0;
                        bus_if.core_H_out = {8{$urandom}};
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d cycles elapsed", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        reset            = 1'b1;
        bus_if.init      = 1'b0;
        bus_if.msg_valid = 1'b0;
        bus_if.msg_word  = '0;
        bus_if.msg_last  = 1'b0;

        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // Single-block "abc" with core_done two cycles into WAIT: latency check
        dly_fix = 2;
        set_abc();
        send_msg(1'b0, 1'b1, ABC_D, 1'b0, 1'b0);
        wait_idle("abc_busy_low");
        check("abc_latency", 256'(dv_cyc - load0_cyc), 256'(83));
        check("abc_digest_held", bus_if.digest, ABC_D);
        dly_fix = 0;

        set_two();
        send_msg(1'b0, 1'b1, TWO_D, 1'b0, 1'b0);
        wait_idle("two_busy_low");

        set_abc();
        send_msg(1'b1, 1'b1, ABC_D, 1'b0, 1'b0);
        wait_idle("gap_busy_low");

        // Reset asserted during round 30 aborts the block
        abort_ok = 1'b1;
        set_abc();
        send_msg(1'b0, 1'b1, ABC_D, 1'b1, 1'b0);
        wait_round(29);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        last_digest = '0;
        @(posedge clk); #1;
        abort_ok = 1'b0;
        set_abc();
        send_msg(1'b1, 1'b1, ABC_D, 1'b0, 1'b0);
        wait_idle("after_abort_busy_low");

        // core_done withheld: error after TIMEOUT WAIT cycles, digest untouched
        withhold = 1'b1;
        set_abc();
        send_msg(1'b0, 1'b1, ABC_D, 1'b1, 1'b0);
        wait_round(63);
        repeat (TIMEOUT) @(negedge clk);
        check("wait_last_error", 256'(bus_if.error), 256'(0));
        check("wait_last_busy",  256'(bus_if.busy),  256'(1));
        @(negedge clk);
        check("timeout_error",  256'(bus_if.error), 256'(1));
        check("timeout_idle",   256'(bus_if.busy),  256'(0));
        check("timeout_digest", bus_if.digest, last_digest);
        check("timeout_no_dv",  256'(bus_if.digest_valid), 256'(0));
        withhold = 1'b0;
        repeat (3) @(negedge clk);
        check("error_sticky", 256'(bus_if.error), 256'(1));
        set_abc();
        send_msg(1'b0, 1'b1, ABC_D, 1'b0, 1'b0);
        wait_idle("after_timeout_busy_low");

        // init and stray core_done during RUN, msg_last on early words: all ignored
        set_two();
        fork
            send_msg(1'b0, 1'b1, TWO_D, 1'b0, 1'b1);
            begin
                wait_round(20);
                @(posedge clk); #1;
                bus_if.init       = 1'b1;
                bus_if.core_done  = 1'b1;
                bus_if.core_H_out = {8{$urandom}};
                @(posedge clk); #1;
                bus_if.init      = 1'b0;
                bus_if.core_done = 1'b0;
            end
        join
        wait_idle("noise_busy_low");

        for (int r = 0; r < 5; r++) begin
            nb = int'($urandom_range(1, 3));
            set_random(nb);
            send_msg(1'($urandom_range(0, 1)), 1'b0, 256'(0), 1'b0, 1'b0);
            wait_idle("rand_busy_low");
        end

        repeat (3) @(negedge clk);
        check("loads_pending",   256'(load_q.size()), 256'(0));
        check("starts_pending",  256'(hin_q.size()),  256'(0));
        check("digests_pending", 256'(dig_q.size()),  256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
